handshaked_fifo_writer: RTL and testbench

HANDSHAKED_FIFO_WRITER -- requirements
Module: handshaked_fifo_writer

---
 rtl/handshaked_fifo_writer_pkg.sv | 15 +
 rtl/handshaked_fifo_writer.sv | 76 +++++++
 tb/tb_handshaked_fifo_writer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/handshaked_fifo_writer_pkg.sv
// Shared stream definitions: skid-buffer state encoding and default widths
// for the handshaked FIFO writer.
package handshaked_fifo_writer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // The encoding doubles as the buffer occupancy reported on the size port.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/handshaked_fifo_writer.sv
// Bridges a valid/ready input stream onto a raw FIFO write port through a
// 2-entry in-order skid buffer, and counts the words written.
module handshaked_fifo_writer
  import handshaked_fifo_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIn_data,
  input  logic                  dataIn_vld,
  output logic                  dataIn_rd,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_en,
  input  logic                  fifo_wait,
  output logic [1:0]            size,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  buf_state_t            state, next_state;
  logic [DATA_WIDTH-1:0] entry0, entry1;
  logic                  head;
  logic                  push, pop, wr_sel;

  assign push      = dataIn_vld & dataIn_rd;
  assign fifo_en   = (state != EMPTY) & ~fifo_wait;
  assign pop       = fifo_en;
  assign fifo_data = head ? entry1 : entry0;
  assign size      = state;

  // With one word held the free slot is the one opposite the head.
  assign wr_sel = head ^ (state == ONE);

  always_comb begin
    next_state = state;
    unique case (state)
      EMPTY: if (push) next_state = ONE;
      ONE: begin
        if (push && !pop)      next_state = FULL;
        else if (!push && pop) next_state = EMPTY;
      end
      FULL:    if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      head      <= 1'b0;
      dataIn_rd <= 1'b0;
    end else begin
      state     <= next_state;
      dataIn_rd <= (next_state != FULL);
      if (pop) head <= ~head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
    end else if (push) begin
      if (wr_sel) entry1 <= dataIn_data;
      else        entry0 <= dataIn_data;
    end
  end

  // Free-running write counter; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wr_count <= '0;
    else if (fifo_en) wr_count <= wr_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_handshaked_fifo_writer.sv
// Directed and randomized checks of the FIFO writer against a queue scoreboard;
// the DUT uses a 4-bit write counter so wrap-around is reachable.
module tb_handshaked_fifo_writer;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dataIn_data;
  logic          dataIn_vld;
  logic          dataIn_rd;
  logic [DW-1:0] fifo_data;
  logic          fifo_en;
  logic          fifo_wait;
  logic [1:0]    size;
  logic [CW-1:0] wr_count;

  int            tests  = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  logic [CW-1:0] exp_count = '0;
  int            writes = 0;
  int            accepted = 0;

  handshaked_fifo_writer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .dataIn_data(dataIn_data), .dataIn_vld(dataIn_vld), .dataIn_rd(dataIn_rd),
    .fifo_data(fifo_data), .fifo_en(fifo_en), .fifo_wait(fifo_wait),
    .size(size), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic vld, input logic [DW-1:0] data);
    dataIn_vld  = vld;
    dataIn_data = data;
    cycle();
  endtask

  // Monitor: accepted words go into the scoreboard, writes pop and compare.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_count = '0;
    end else begin
      check_output("wr_count_track", 32'(wr_count), 32'(exp_count));
      if (dataIn_vld && dataIn_rd) begin
        sb.push_back(dataIn_data);
        accepted++;
      end
      if (fifo_en) begin
        tests++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("[TB] FAIL sb_underflow: observed write %0h expected no write", fifo_data);
        end
        if (sb.size() != 0) check_output("fifo_data", 32'(fifo_data), 32'(sb.pop_front()));
        exp_count = exp_count + 1'b1;
        writes++;
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b1; dataIn_vld = 1'b0; dataIn_data = '0; fifo_wait = 1'b0;
    #3;
    check_output("rst_size", 32'(size), 0);
    check_output("rst_en", 32'(fifo_en), 0);
    check_output("rst_rd", 32'(dataIn_rd), 0);
    check_output("rst_count", 32'(wr_count), 0);
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    check_output("rd_after_rst", 32'(dataIn_rd), 1);

    // Three words, no backpressure.
    apply_stimulus(1'b1, 8'h11);
    check_output("lat_size", 32'(size), 1);
    check_output("lat_en", 32'(fifo_en), 1);
    check_output("lat_data", 32'(fifo_data), 32'h11);
    apply_stimulus(1'b1, 8'h22);
    apply_stimulus(1'b1, 8'h33);
    apply_stimulus(1'b0, 8'h00);
    cycle();
    check_output("s1_count", 32'(wr_count), 3);
    check_output("s1_size", 32'(size), 0);

    // Backpressure fills the buffer.
    fifo_wait = 1'b1;
    apply_stimulus(1'b1, 8'hA0);
    check_output("bp_size1", 32'(size), 1);
    check_output("bp_rd1", 32'(dataIn_rd), 1);
    apply_stimulus(1'b1, 8'hA1);
    dataIn_vld = 1'b0;
    check_output("bp_size2", 32'(size), 2);
    check_output("bp_rd0", 32'(dataIn_rd), 0);
    check_output("bp_en0", 32'(fifo_en), 0);
    cycle(); cycle();
    check_output("bp_hold_size", 32'(size), 2);
    check_output("bp_hold_rd", 32'(dataIn_rd), 0);
    fifo_wait = 1'b0;
    #1;
    check_output("bp_release_en", 32'(fifo_en), 1);
    check_output("bp_head", 32'(fifo_data), 32'hA0);
    cycle();
    check_output("bp_pop_size", 32'(size), 1);
    check_output("bp_pop_rd", 32'(dataIn_rd), 1);
    check_output("bp_second", 32'(fifo_data), 32'hA1);
    cycle();
    check_output("bp_count", 32'(wr_count), 5);
    check_output("bp_empty", 32'(size), 0);

    // Continuous streaming: one write per cycle, occupancy steady at one.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 8'(8'h50 + i));
      check_output("stream_size", 32'(size), 1);
      check_output("stream_rd", 32'(dataIn_rd), 1);
    end
    apply_stimulus(1'b0, 8'h00);
    check_output("stream_count", 32'(wr_count), 13);
    check_output("stream_empty", 32'(size), 0);

    // Reset while full discards the buffer and aborts the pending write.
    fifo_wait = 1'b1;
    apply_stimulus(1'b1, 8'hC0);
    apply_stimulus(1'b1, 8'hC1);
    dataIn_vld = 1'b0;
    check_output("pre_rst_size", 32'(size), 2);
    fifo_wait = 1'b0;
    rst = 1'b1;
    #1;
    check_output("mid_rst_en", 32'(fifo_en), 0);
    check_output("mid_rst_size", 32'(size), 0);
    check_output("mid_rst_count", 32'(wr_count), 0);
    check_output("mid_rst_rd", 32'(dataIn_rd), 0);
    cycle();
    rst = 1'b0;
    cycle();
    check_output("post_rst_rd", 32'(dataIn_rd), 1);
    check_output("post_rst_size", 32'(size), 0);

    // Counter wrap with a 4-bit counter.
    for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 8'(i));
    apply_stimulus(1'b0, 8'h00);
    check_output("wrap_15", 32'(wr_count), 15);
    apply_stimulus(1'b1, 8'hEE);
    apply_stimulus(1'b0, 8'h00);
    check_output("wrap_0", 32'(wr_count), 0);
    apply_stimulus(1'b1, 8'hEF);
    apply_stimulus(1'b0, 8'h00);
    check_output("wrap_1", 32'(wr_count), 1);

    // Random valid with toggling backpressure over 1000 accepted words.
    accepted = 0;
    writes   = 0;
    budget   = 0;
    while (accepted < 1000 && budget < 20000) begin
      fifo_wait = ~fifo_wait;
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom));
      tests++;
      assert (size <= 2'd2) else begin
        errors++;
        $error("[TB] FAIL rand_size: observed %0d expected <= 2", size);
      end
      budget++;
    end
    dataIn_vld = 1'b0;
    fifo_wait  = 1'b0;
    check_output("rand_budget", 32'(accepted >= 1000), 1);
    budget = 0;
    while (size != 0 && budget < 20) begin
      cycle();
      budget++;
    end
    cycle();
    check_output("rand_drained", 32'(size), 0);
    check_output("rand_sb_empty", 32'(sb.size()), 0);
    check_output("rand_writes", 32'(writes), 32'(accepted));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
